// File: rtl/platypus_pkg.sv
// Shared definitions for the FT2232H synchronous-FIFO receive path:
// FT bus levels, packet framing constants and FSM state encodings.
package platypus_pkg;

   // FT2232H control lines are active-low
   localparam logic FT_ASSERT   = 1'b0;
   localparam logic FT_DEASSERT = 1'b1;

   // Command packet framing: SYNC, ADDR, DHI, DLO, CSUM
   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
   localparam int         PKT_LEN           = 5;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_OE,
      RD_READ
   } rd_state_t;

   typedef enum logic [2:0] {
      PS_SYNC,
      PS_ADDR,
      PS_DHI,
      PS_DLO,
      PS_CSUM,
      PS_HOLD
   } ps_state_t;

   // Packet checksum: XOR of the three payload bytes
   function automatic logic [7:0] pkt_csum(input logic [7:0] addr,
                                           input logic [7:0] dhi,
                                           input logic [7:0] dlo);
      return addr ^ dhi ^ dlo;
   endfunction

endpackage

// File: rtl/ft_rx_skid_fifo.sv
// Small synchronous FIFO between the FT reader and the packet parser.
// Storage is a plain array with a registered read port so it maps to RAM;
// dout_o updates on the edge that accepts a pop.
module ft_rx_skid_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           din_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           dout_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       empty_o,
   output logic                       full_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] dout_reg;
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             push_ok;
   logic             pop_ok;

   assign empty_o = (count_reg == '0);
   assign full_o  = (count_reg == (AW+1)'(DEPTH));
   assign count_o = count_reg;
   assign dout_o  = dout_reg;
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // Pointers and occupancy; pointers wrap naturally at DEPTH (power of 2)
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // RAM write port and registered read port (no reset so it infers RAM)
   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_ptr_reg] <= din_i;
      if (pop_ok)  dout_reg <= mem[rd_ptr_reg];
   end

   // The reader's watermark must make a push into a full FIFO impossible
   a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i) !(push_i && full_o));

endmodule

// File: rtl/ft245_rx_cmd.sv
// FT2232H FT245 synchronous-FIFO receive path: reads host bytes into a skid
// FIFO and parses SYNC/ADDR/DHI/DLO/CSUM packets into register-write commands
// with a valid/ready handshake. Bad checksums bump a saturating error counter.
module ft245_rx_cmd
   import platypus_pkg::*;
#(
   parameter int         FIFO_DEPTH = 8,
   parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT,
   parameter int         ERR_W      = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             en_i,
   input  logic             ft_rxf_i,
   input  logic [7:0]       ft_data_i,
   output logic             ft_oe_o,
   output logic             ft_rd_o,
   input  logic             ft_tx_busy_i,
   output logic             cmd_valid_o,
   input  logic             cmd_ready_i,
   output logic [7:0]       cmd_addr_o,
   output logic [15:0]      cmd_data_o,
   output logic [ERR_W-1:0] err_cnt_o
);

   localparam int             CW       = $clog2(FIFO_DEPTH) + 1;
   // Reader may only start with room for the bytes it can take before stopping
   localparam logic [CW-1:0]  START_MAX = CW'(FIFO_DEPTH - 3);
   // Stop reading once occupancy (including this edge's byte) reaches this
   localparam logic [CW-1:0]  HI_WM     = CW'(FIFO_DEPTH - 2);

   rd_state_t        rd_state_reg;
   logic             oe_reg;
   logic             rd_reg;

   ps_state_t        ps_state_reg;
   logic             byte_valid_reg;
   logic [7:0]       addr_sh_reg;
   logic [7:0]       dhi_sh_reg;
   logic [7:0]       dlo_sh_reg;
   logic             cmd_valid_reg;
   logic [7:0]       cmd_addr_reg;
   logic [15:0]      cmd_data_reg;
   logic [ERR_W-1:0] err_reg;

   logic             capture;
   logic             pop;
   logic             consume;
   logic [7:0]       fifo_dout;
   logic [CW-1:0]    fifo_count;
   logic [CW-1:0]    count_after;
   logic             fifo_empty;
   logic             fifo_full;
   logic             start_ok;

   assign ft_oe_o     = oe_reg;
   assign ft_rd_o     = rd_reg;
   assign cmd_valid_o = cmd_valid_reg;
   assign cmd_addr_o  = cmd_addr_reg;
   assign cmd_data_o  = cmd_data_reg;
   assign err_cnt_o   = err_reg;

   // A byte is taken on every edge where our RD# and the FT's RXF# are both low
   assign capture     = (rd_reg == FT_ASSERT) && (ft_rxf_i == FT_ASSERT);
   assign count_after = fifo_count + {{(CW-1){1'b0}}, capture};
   assign start_ok    = en_i && (ft_rxf_i == FT_ASSERT) && !ft_tx_busy_i &&
                        !fifo_full && (fifo_count <= START_MAX);

   // The FIFO output register acts as a one-byte stage in front of the parser
   assign consume = byte_valid_reg && (ps_state_reg != PS_HOLD);
   assign pop     = !fifo_empty && (!byte_valid_reg || consume);

   ft_rx_skid_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_skid (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (capture),
      .din_i   (ft_data_i),
      .pop_i   (pop),
      .dout_o  (fifo_dout),
      .count_o (fifo_count),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   // Reader FSM: IDLE -> OE (bus turnaround) -> READ, registered OE#/RD#
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rd_state_reg <= RD_IDLE;
         oe_reg       <= FT_DEASSERT;
         rd_reg       <= FT_DEASSERT;
      end else begin
         case (rd_state_reg)
            RD_IDLE: begin
               if (start_ok) begin
                  rd_state_reg <= RD_OE;
                  oe_reg       <= FT_ASSERT;
               end
            end
            RD_OE: begin
               if (ft_tx_busy_i) begin
                  rd_state_reg <= RD_IDLE;
                  oe_reg       <= FT_DEASSERT;
               end else begin
                  rd_state_reg <= RD_READ;
                  rd_reg       <= FT_ASSERT;
               end
            end
            RD_READ: begin
               if ((ft_rxf_i == FT_DEASSERT) || !en_i || ft_tx_busy_i ||
                   (count_after >= HI_WM)) begin
                  rd_state_reg <= RD_IDLE;
                  oe_reg       <= FT_DEASSERT;
                  rd_reg       <= FT_DEASSERT;
               end
            end
            default: begin
               rd_state_reg <= RD_IDLE;
               oe_reg       <= FT_DEASSERT;
               rd_reg       <= FT_DEASSERT;
            end
         endcase
      end
   end

   // Parser FSM: frame packets, verify checksum, hold command until accepted
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ps_state_reg   <= PS_SYNC;
         byte_valid_reg <= 1'b0;
         addr_sh_reg    <= '0;
         dhi_sh_reg     <= '0;
         dlo_sh_reg     <= '0;
         cmd_valid_reg  <= 1'b0;
         cmd_addr_reg   <= '0;
         cmd_data_reg   <= '0;
         err_reg        <= '0;
      end else begin
         if (pop)          byte_valid_reg <= 1'b1;
         else if (consume) byte_valid_reg <= 1'b0;

         case (ps_state_reg)
            PS_SYNC: begin
               if (consume && (fifo_dout == SYNC_BYTE)) ps_state_reg <= PS_ADDR;
            end
            PS_ADDR: begin
               if (consume) begin
                  addr_sh_reg  <= fifo_dout;
                  ps_state_reg <= PS_DHI;
               end
            end
            PS_DHI: begin
               if (consume) begin
                  dhi_sh_reg   <= fifo_dout;
                  ps_state_reg <= PS_DLO;
               end
            end
            PS_DLO: begin
               if (consume) begin
                  dlo_sh_reg   <= fifo_dout;
                  ps_state_reg <= PS_CSUM;
               end
            end
            PS_CSUM: begin
               if (consume) begin
                  if (fifo_dout == pkt_csum(addr_sh_reg, dhi_sh_reg, dlo_sh_reg)) begin
                     cmd_addr_reg  <= addr_sh_reg;
                     cmd_data_reg  <= {dhi_sh_reg, dlo_sh_reg};
                     cmd_valid_reg <= 1'b1;
                     ps_state_reg  <= PS_HOLD;
                  end else begin
                     if (err_reg != '1) err_reg <= err_reg + 1'b1;
                     ps_state_reg <= PS_SYNC;
                  end
               end
            end
            PS_HOLD: begin
               if (cmd_valid_reg && cmd_ready_i) begin
                  cmd_valid_reg <= 1'b0;
                  ps_state_reg  <= PS_SYNC;
               end
            end
            default: ps_state_reg <= PS_SYNC;
         endcase
      end
   end

endmodule

// File: tb/tb_ft245_rx_cmd.sv
// Bench for ft245_rx_cmd: an FT2232H host model feeds bytes from a queue,
// a monitor collects accepted commands and watches bus/handshake rules, and
// a packet-scanning reference model predicts commands and checksum errors.
module tb_ft245_rx_cmd;
   import platypus_pkg::*;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        en_i;
   logic        ft_rxf_i;
   logic [7:0]  ft_data_i;
   logic        ft_oe_o;
   logic        ft_rd_o;
   logic        ft_tx_busy_i;
   logic        cmd_valid_o;
   logic        cmd_ready_i;
   logic [7:0]  cmd_addr_o;
   logic [15:0] cmd_data_o;
   logic [7:0]  err_cnt_o;

   always #5 clk_i = ~clk_i;

   ft245_rx_cmd dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .en_i         (en_i),
      .ft_rxf_i     (ft_rxf_i),
      .ft_data_i    (ft_data_i),
      .ft_oe_o      (ft_oe_o),
      .ft_rd_o      (ft_rd_o),
      .ft_tx_busy_i (ft_tx_busy_i),
      .cmd_valid_o  (cmd_valid_o),
      .cmd_ready_i  (cmd_ready_i),
      .cmd_addr_o   (cmd_addr_o),
      .cmd_data_o   (cmd_data_o),
      .err_cnt_o    (err_cnt_o)
   );

   int          checks   = 0;
   int          failures = 0;
   int          exp_err  = 0;
   int          proto_err = 0;
   int          cyc = 0;
   int          last_cap_edge = 0;
   int          first_valid_cyc = 0;

   logic [7:0]  host_q[$];     // bytes still inside the FT2232H RX FIFO
   logic [7:0]  stream_q[$];   // bytes sent since the last check
   logic [23:0] got_q[$];      // accepted {addr, data}
   logic [23:0] exp_q[$];
   logic        host_hold = 1'b0;

   logic        valid_prev = 1'b0;
   logic        ready_prev = 1'b0;
   logic        busy_prev  = 1'b0;
   logic [23:0] cmd_prev   = '0;

   always @(posedge clk_i) cyc++;

   // FT2232H model and monitor: drive bus just after negedge, sample before posedge
   always @(negedge clk_i) begin
      #1;
      ft_rxf_i  = (host_q.size() == 0 || host_hold) ? 1'b1 : 1'b0;
      ft_data_i = (host_q.size() != 0) ? host_q[0] : 8'h00;
      #2;
      if (!reset_i) begin
         if (ft_rd_o == 1'b0 && ft_rxf_i == 1'b0) begin
            void'(host_q.pop_front());
            last_cap_edge = cyc + 1;
         end
         if (ft_rd_o == 1'b0 && ft_oe_o == 1'b1) proto_err++;
         if (busy_prev && ft_tx_busy_i && (ft_oe_o !== 1'b1 || ft_rd_o !== 1'b1)) proto_err++;
         if (valid_prev && !ready_prev &&
             (cmd_valid_o !== 1'b1 || {cmd_addr_o, cmd_data_o} !== cmd_prev)) proto_err++;
         if (cmd_valid_o && !valid_prev) first_valid_cyc = cyc;
         if (cmd_valid_o && cmd_ready_i) got_q.push_back({cmd_addr_o, cmd_data_o});
      end
      valid_prev = cmd_valid_o;
      ready_prev = cmd_ready_i;
      busy_prev  = ft_tx_busy_i;
      cmd_prev   = {cmd_addr_o, cmd_data_o};
   end

   // Reference: scan the byte stream for SYNC-framed packets; returns checksum errors
   function automatic int ref_parse();
      int i = 0;
      int errs = 0;
      exp_q.delete();
      while (i < stream_q.size()) begin
         if (stream_q[i] != SYNC_BYTE_DEFAULT) begin
            i++;
         end else if (i + PKT_LEN - 1 >= stream_q.size()) begin
            break;
         end else begin
            if (stream_q[i+4] == (stream_q[i+1] ^ stream_q[i+2] ^ stream_q[i+3]))
               exp_q.push_back({stream_q[i+1], stream_q[i+2], stream_q[i+3]});
            else
               errs++;
            i += PKT_LEN;
         end
      end
      return errs;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic send_byte(input logic [7:0] b);
      host_q.push_back(b);
      stream_q.push_back(b);
   endtask

   task automatic send_pkt(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l,
                           input logic [7:0] c);
      send_byte(8'hA5); send_byte(a); send_byte(h); send_byte(l); send_byte(c);
   endtask

   task automatic wait_cmds(input int n, input int budget, input string name);
      int k = 0;
      while (got_q.size() < n && k < budget) begin
         @(negedge clk_i);
         k++;
      end
      checks++;
      if (got_q.size() < n) begin
         failures++;
         $display("FAIL %s_timeout: got %0d commands, expected %0d", name, got_q.size(), n);
      end
      tick(12);
   endtask

   task automatic check_stream(input string name);
      int errs;
      int n;
      errs = ref_parse();
      exp_err += errs;
      if (exp_err > 255) exp_err = 255;
      checks++;
      if (got_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL %s_count: got %0d commands, expected %0d", name, got_q.size(), exp_q.size());
      end
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL %s_cmd%0d: got addr/data %06h, expected %06h", name, i, got_q[i], exp_q[i]);
         end
      end
      checks++;
      if (err_cnt_o !== 8'(exp_err)) begin
         failures++;
         $display("FAIL %s_err: got %0d, expected %0d", name, err_cnt_o, exp_err);
      end
      got_q.delete();
      stream_q.delete();
   endtask

   task automatic check_reset_values(input string name);
      checks++;
      if ({ft_oe_o, ft_rd_o, cmd_valid_o} !== 3'b110) begin
         failures++;
         $display("FAIL %s_ctrl: got oe/rd/valid %03b, expected 110", name, {ft_oe_o, ft_rd_o, cmd_valid_o});
      end
      checks++;
      if ({cmd_addr_o, cmd_data_o} !== 24'h0) begin
         failures++;
         $display("FAIL %s_cmd: got %06h, expected 000000", name, {cmd_addr_o, cmd_data_o});
      end
      checks++;
      if (err_cnt_o !== 8'h00) begin
         failures++;
         $display("FAIL %s_err: got %0d, expected 0", name, err_cnt_o);
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b1; en_i = 1'b0; cmd_ready_i = 1'b0; ft_tx_busy_i = 1'b0;
      tick(4);
      check_reset_values("reset");
      reset_i = 1'b0; en_i = 1'b1; cmd_ready_i = 1'b1;
      tick(2);
      $display("tb: reset sequence done");
   endtask

   task automatic test_single();
      send_pkt(8'h03, 8'h12, 8'h34, 8'h25);
      wait_cmds(1, 200, "single");
      checks++;
      if (first_valid_cyc - last_cap_edge != 2) begin
         failures++;
         $display("FAIL single_latency: got %0d edges, expected 2", first_valid_cyc - last_cap_edge);
      end
      check_stream("single");
      $display("tb: single packet A5 03 12 34 25");
   endtask

   task automatic test_bad_csum();
      send_pkt(8'h03, 8'h12, 8'h34, 8'h00);
      send_pkt(8'h03, 8'h12, 8'h34, 8'h25);
      wait_cmds(1, 300, "bad_csum");
      check_stream("bad_csum");
      $display("tb: bad checksum then good packet");
   endtask

   task automatic test_resync();
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
      send_pkt(8'h07, 8'h00, 8'h01, 8'h06);
      wait_cmds(1, 300, "resync");
      check_stream("resync");
      $display("tb: junk bytes then packet 07/0001");
   endtask

   task automatic test_backpressure();
      logic [7:0] a, h, l;
      logic [23:0] first;
      cmd_ready_i = 1'b0;
      for (int p = 0; p < 3; p++) begin
         a = 8'($urandom_range(0, 255));
         h = 8'($urandom_range(0, 255));
         l = 8'($urandom_range(0, 255));
         if (p == 0) first = {a, h, l};
         send_pkt(a, h, l, a ^ h ^ l);
      end
      tick(80);
      checks++;
      if (cmd_valid_o !== 1'b1 || {cmd_addr_o, cmd_data_o} !== first) begin
         failures++;
         $display("FAIL bp_hold: got valid %0b cmd %06h, expected 1 %06h",
                  cmd_valid_o, {cmd_addr_o, cmd_data_o}, first);
      end
      checks++;
      if (host_q.size() == 0) begin
         failures++;
         $display("FAIL bp_ft_holds: got 0 bytes left in FT, expected more than 0");
      end
      checks++;
      if (ft_rd_o !== 1'b1) begin
         failures++;
         $display("FAIL bp_rd_released: got rd %0b, expected 1", ft_rd_o);
      end
      cmd_ready_i = 1'b1;
      wait_cmds(3, 400, "bp");
      check_stream("bp");
      $display("tb: backpressure with 3 packets");
   endtask

   task automatic test_busy_pause();
      send_byte(8'hA5); send_byte(8'h0A); send_byte(8'h12);
      tick(20);
      host_hold = 1'b1;
      send_byte(8'h34); send_byte(8'h2C);
      tick(4);
      ft_tx_busy_i = 1'b1;
      tick(2);
      host_hold = 1'b0;
      tick(10);
      checks++;
      if (host_q.size() != 2 || ft_rd_o !== 1'b1 || ft_oe_o !== 1'b1) begin
         failures++;
         $display("FAIL busy_stall: got ft bytes %0d rd %0b oe %0b, expected 2 1 1",
                  host_q.size(), ft_rd_o, ft_oe_o);
      end
      checks++;
      if (cmd_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL busy_no_cmd: got valid %0b, expected 0", cmd_valid_o);
      end
      ft_tx_busy_i = 1'b0;
      wait_cmds(1, 200, "busy");
      check_stream("busy");
      $display("tb: rxf pause and tx busy mid packet");
   endtask

   task automatic test_reset_mid();
      send_byte(8'hA5); send_byte(8'h03);
      tick(20);
      reset_i = 1'b1;
      tick(2);
      check_reset_values("reset_mid");
      reset_i = 1'b0;
      exp_err = 0;
      stream_q.delete();
      got_q.delete();
      tick(2);
      send_pkt(8'h03, 8'h12, 8'h34, 8'h25);
      wait_cmds(1, 200, "reset_mid");
      check_stream("after_reset");
      $display("tb: reset after ADDR byte then full packet");
   endtask

   task automatic test_random();
      logic [7:0] a, h, l, c, b;
      int n_exp;
      int k = 0;
      for (int p = 0; p < 40; p++) begin
         for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            send_byte(b);
         end
         a = 8'($urandom_range(0, 255));
         h = 8'($urandom_range(0, 255));
         l = 8'($urandom_range(0, 255));
         c = a ^ h ^ l;
         if ($urandom_range(0, 4) == 0) c = c ^ 8'($urandom_range(1, 255));
         send_pkt(a, h, l, c);
      end
      void'(ref_parse());
      n_exp = exp_q.size();
      while ((host_q.size() != 0 || got_q.size() < n_exp) && k < 20000) begin
         @(negedge clk_i);
         cmd_ready_i  = ($urandom_range(0, 3) != 0);
         en_i         = ($urandom_range(0, 7) != 0);
         ft_tx_busy_i = ($urandom_range(0, 15) == 0);
         host_hold    = ($urandom_range(0, 7) == 0);
         k++;
      end
      cmd_ready_i = 1'b1; en_i = 1'b1; ft_tx_busy_i = 1'b0; host_hold = 1'b0;
      checks++;
      if (k >= 20000) begin
         failures++;
         $display("FAIL random_timeout: got %0d commands, expected %0d", got_q.size(), n_exp);
      end
      tick(30);
      check_stream("random");
      $display("tb: random stream of 40 packets with junk and corruption");
   endtask

   task automatic test_protocol();
      checks++;
      if (proto_err != 0) begin
         failures++;
         $display("FAIL protocol: got %0d bus/handshake violations, expected 0", proto_err);
      end
   endtask

   initial begin
      reset_i = 1'b1; en_i = 1'b0; cmd_ready_i = 1'b0; ft_tx_busy_i = 1'b0;
      ft_rxf_i = 1'b1; ft_data_i = 8'h00;
      test_reset();
      test_single();
      test_bad_csum();
      test_resync();
      test_backpressure();
      test_busy_pause();
      test_reset_mid();
      test_random();
      test_protocol();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #800000;
      failures++;
      $display("FAIL watchdog: got no end of test, expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
